// File: rtl/line.sv
// VGA horizontal line timing generator: ACTIVE/FRONT_PORCH/SYNC_PULSE/BACK_PORCH.
// Define LINE_EOL_EN to add a registered end-of-line strobe (eol).
package vga_pkg;
  typedef enum logic [1:0] {
    ACTIVE      = 2'd0,
    FRONT_PORCH = 2'd1,
    SYNC_PULSE  = 2'd2,
    BACK_PORCH  = 2'd3
  } VGA_state_e;
endpackage

module line
  import vga_pkg::*;
#(
  parameter int LINE_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LINE_WIDTH-1:0] visible_area,
  input  logic [LINE_WIDTH-1:0] front_porch,
  input  logic [LINE_WIDTH-1:0] sync_pulse,
  input  logic [LINE_WIDTH-1:0] back_porch,
  input  logic                  polarity,
  output logic                  sync,
  output VGA_state_e            state
`ifdef LINE_EOL_EN
  ,
  output logic                  eol
`endif
);

  localparam int W = LINE_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W:0] ONE_X = (W+1)'(1);

  logic [3:0][W-1:0] len;
  assign len = {back_porch, sync_pulse, front_porch, visible_area};

  VGA_state_e state_q, state_d;
  logic [W-1:0] counter, counter_d;
  logic sync_q, sync_d;
  logic live_q;
  logic done, found;
  logic [1:0] pos;
  VGA_state_e nxt_ph;

  always_comb begin
    done = ({1'b0, counter} + ONE_X) >= {1'b0, len[state_q]};
    found = 1'b0;
    nxt_ph = ACTIVE;
    // k = 4 lands back on the current phase when it is the only non-zero one
    for (int k = 1; k <= 4; k++) begin
      pos = state_q + 2'(k);
      if (!found && len[pos] != '0) begin
        found = 1'b1;
        nxt_ph = VGA_state_e'(pos);
      end
    end
    state_d = state_q;
    counter_d = counter + ONE;
    if (done) begin
      counter_d = '0;
      state_d = found ? nxt_ph : ACTIVE;
    end
    sync_d = (state_d == SYNC_PULSE) ? polarity : ~polarity;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ACTIVE;
      counter <= '0;
      sync_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      counter <= counter_d;
      sync_q  <= sync_d;
      live_q  <= 1'b1;
    end
  end

  // Until the first edge after reset, sync tracks the idle level directly
  assign sync = live_q ? sync_q : ~polarity;
  assign state = state_q;

`ifdef LINE_EOL_EN
  function automatic logic ends_line(
    input logic [1:0]        ph,
    input logic [W-1:0]      cnt,
    input logic [3:0][W-1:0] lens
  );
    logic later;
    later = 1'b0;
    for (int k = 0; k < 4; k++)
      if (k > int'(ph) && lens[k] != '0) later = 1'b1;
    return (lens != '0) && !later &&
           (({1'b0, cnt} + ONE_X) >= {1'b0, lens[ph]});
  endfunction

  logic eol_q, eol_d;

  assign eol_d = ends_line(state_d, counter_d, len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) eol_q <= 1'b0;
    else       eol_q <= eol_d;
  end

  assign eol = eol_q;
`endif

endmodule

// File: tb/tb_line.sv
// Directed bench for the line timing generator.
// Expected phase/counter/sync sequences come from the programmed lengths.
module tb_line;
  import vga_pkg::*;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [W-1:0] va, fp, sp, bp;
  logic pol;
  logic sync;
  VGA_state_e state;
`ifdef LINE_EOL_EN
  logic eol;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  line #(.LINE_WIDTH(W)) dut (
    .clk(clk),
    .rstn(rstn),
    .visible_area(va),
    .front_porch(fp),
    .sync_pulse(sp),
    .back_porch(bp),
    .polarity(pol),
    .sync(sync),
    .state(state)
`ifdef LINE_EOL_EN
    ,
    .eol(eol)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_cyc(input int ph, input int cnt, input logic eol_x);
    logic sx;
    sx = (ph == 2) ? pol : !pol;
    check("state", 32'(state), 32'(ph));
    check("counter", 32'(dut.counter), 32'(cnt));
    check("sync", 32'(sync), 32'(sx));
`ifdef LINE_EOL_EN
    check("eol", 32'(eol), 32'(eol_x));
`else
    if (eol_x === 1'bx) $display("unexpected x");
`endif
  endtask

  task automatic run_seg(input int ph, input int from, input int to,
                         input logic last);
    for (int i = from; i <= to; i++) begin
      chk_cyc(ph, i, last && (i == to));
      @(negedge clk);
    end
  endtask

  task automatic run_line();
    int l[4];
    int lastp;
    l[0] = int'(va); l[1] = int'(fp); l[2] = int'(sp); l[3] = int'(bp);
    lastp = 0;
    for (int k = 0; k < 4; k++) if (l[k] != 0) lastp = k;
    for (int k = 0; k < 4; k++)
      if (l[k] != 0) run_seg(k, 0, l[k] - 1, k == lastp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk_cyc(0, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    va = 12'd640; fp = 12'd16; sp = 12'd96; bp = 12'd48;
    pol = 1'b0;
    #1;
    chk_cyc(0, 0, 1'b0);
    pol = 1'b1;
    #1;
    check("rst_sync_pol1", 32'(sync), 32'd0);
    pol = 1'b0;
    #1;
    check("rst_sync_pol0", 32'(sync), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // 640x480 line, polarity low, three lines
    repeat (3) run_line();

    // polarity high
    pol = 1'b1;
    do_reset();
    repeat (2) run_line();
    pol = 1'b0;

    // zero-length front porch
    fp = 12'd0;
    do_reset();
    repeat (2) run_line();
    fp = 12'd16;

    // reset during sync at counter 50
    do_reset();
    run_seg(0, 0, 639, 1'b0);
    run_seg(1, 0, 15, 1'b0);
    run_seg(2, 0, 49, 1'b0);
    chk_cyc(2, 50, 1'b0);
    do_reset();
    run_line();

    // visible area shortened mid-phase
    do_reset();
    run_seg(0, 0, 299, 1'b0);
    chk_cyc(0, 300, 1'b0);
    va = 12'd100;
    @(negedge clk);
    run_seg(1, 0, 15, 1'b0);
    run_seg(2, 0, 95, 1'b0);
    run_seg(3, 0, 47, 1'b1);
    run_line();
    va = 12'd640;

    // all lengths 1
    va = 12'd1; fp = 12'd1; sp = 12'd1; bp = 12'd1;
    do_reset();
    repeat (3) run_line();

    // zero visible area: reset cycle then skip ACTIVE
    va = 12'd0;
    do_reset();
    chk_cyc(0, 0, 1'b0);
    @(negedge clk);
    repeat (2) run_line();

    // polarity change mid sync takes effect on the next edge
    va = 12'd2; fp = 12'd1; sp = 12'd3; bp = 12'd1;
    do_reset();
    run_seg(0, 0, 1, 1'b0);
    run_seg(1, 0, 0, 1'b0);
    run_seg(2, 0, 0, 1'b0);
    chk_cyc(2, 1, 1'b0);
    pol = 1'b1;
    #1;
    check("pol_hold", 32'(sync), 32'd0);
    @(negedge clk);
    chk_cyc(2, 2, 1'b0);
    @(negedge clk);
    run_seg(3, 0, 0, 1'b1);
    run_line();
    pol = 1'b0;

    // all zero: parked in ACTIVE
    va = '0; fp = '0; sp = '0; bp = '0;
    do_reset();
    repeat (5) begin
      chk_cyc(0, 0, 1'b0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/line.md
LINE -- requirements
Module: line

Interface
REQ-001 The block SHALL have parameter LINE_WIDTH, default 12, which sets the width of the timing inputs and of the phase counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the pixel clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port visible_area, input, LINE_WIDTH bits: number of cycles in the active phase.
REQ-005 The block SHALL have port front_porch, input, LINE_WIDTH bits: number of cycles in the front-porch phase.
REQ-006 The block SHALL have port sync_pulse, input, LINE_WIDTH bits: number of cycles in the sync phase.
REQ-007 The block SHALL have port back_porch, input, LINE_WIDTH bits: number of cycles in the back-porch phase.
REQ-008 The block SHALL have port polarity, input, 1 bit: asserted level of sync (1 = active-high, 0 = active-low).
REQ-009 The block SHALL have port sync, output, 1 bit: registered sync pulse.
REQ-010 The block SHALL have port state, output, type VGA_state_e from vga_pkg (2 bits): current phase, encoded ACTIVE=0, FRONT_PORCH=1, SYNC_PULSE=2, BACK_PORCH=3.

Function
REQ-011 The block SHALL hold an internal register named counter, LINE_WIDTH bits wide, which gives the cycle index within the current phase and is readable hierarchically.
REQ-012 The phases SHALL cycle ACTIVE -> FRONT_PORCH -> SYNC_PULSE -> BACK_PORCH -> ACTIVE.
REQ-013 counter SHALL start at 0 on entry to each phase and increment by 1 per clock.
REQ-014 When counter >= (phase length - 1), the next clock SHALL reset counter to 0 and advance state to the next phase.
- The >= comparison makes a length reduced mid-phase end that phase at the next clock.
REQ-015 A phase whose length input is 0 SHALL be skipped: the transition goes directly to the next phase with a non-zero length, within the same clock.
REQ-016 If all four lengths are 0, state SHALL remain ACTIVE and counter SHALL remain 0.
REQ-017 sync SHALL be registered together with state, so that in every cycle sync == polarity exactly when state == SYNC_PULSE, and sync == ~polarity otherwise.
REQ-018 A change of polarity SHALL affect sync from the next clock edge.
REQ-019 Line period SHALL equal visible_area + front_porch + sync_pulse + back_porch cycles, with zero latency between phases (no idle cycles).
REQ-020 Timing inputs SHALL be sampled every cycle (not latched per line).
REQ-021 counter arithmetic SHALL be unsigned LINE_WIDTH bits and SHALL never wrap past phase length - 1.

Reset
REQ-022 While rstn = 0, counter SHALL be 0, state SHALL be ACTIVE and sync SHALL be ~polarity, applied asynchronously.
REQ-023 After rstn rises, the first rising clk edge SHALL increment counter to 1, starting the ACTIVE phase.
- This applies unless visible_area <= 1, in which case REQ-014 and REQ-015 govern the transition.
REQ-024 Asserting rstn mid-line SHALL immediately restore the reset values of REQ-022; no partial line state is retained.

Configuration
REQ-025 With macro LINE_EOL_EN defined, the block SHALL add output port eol (1 bit, registered, reset 0).
- eol is high for exactly one cycle: the last cycle of the line, i.e. the cycle before state returns to ACTIVE with counter 0.
REQ-026 Without LINE_EOL_EN, port eol and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-027 640x480@60 timing, polarity=0 (640/16/96/48), 3 lines after reset -> per line:
- ACTIVE counter 0..639, FRONT_PORCH 0..15, SYNC_PULSE 0..95 with sync=0, BACK_PORCH 0..47 with sync=1;
- period 800 cycles.
REQ-028 Same timing with polarity=1 -> sync=1 only during the 96 SYNC_PULSE cycles, otherwise 0.
REQ-029 front_porch=0, other lengths as in REQ-027 -> ACTIVE counter 639 is followed directly by SYNC_PULSE counter 0; period 784.
REQ-030 rstn pulsed low during SYNC_PULSE at counter 50 -> immediately state=ACTIVE, counter=0, sync=~polarity; a normal line resumes after release.
REQ-031 visible_area reduced from 640 to 100 while counter=300 in ACTIVE -> FRONT_PORCH counter 0 on the next clock.
REQ-032 With LINE_EOL_EN, REQ-027 stimulus -> eol high once per 800 cycles, coinciding with BACK_PORCH counter 47.
